// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between the FIFO pointer controller and its users.
// The master side issues push/pop/clr_err; the slave (controller) returns addresses and flags.
interface fifo_ctrl_if #(
  parameter int AW = 3
);
  logic          push;
  logic          pop;
  logic          clr_err;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, clr_err,
    input  wr_addr, wr_en, rd_addr, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, pop, clr_err,
    output wr_addr, wr_en, rd_addr, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a 2^AW-entry show-ahead FIFO in an external register file.
// Full/empty come only from the occupancy count; pointers are never compared.
module fifo_ctrl #(
  parameter int AW       = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_ctrl_if.slave  bus
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(1 << AW);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          full, empty, acc_push, acc_pop;

  assign full     = (count_reg == DEPTH_C);
  assign empty    = (count_reg == '0);
  assign acc_push = bus.push & ~full;
  assign acc_pop  = bus.pop & ~empty;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg + AW'(acc_push);
    rd_ptr_next    = rd_ptr_reg + AW'(acc_pop);
    count_next     = count_reg + (AW+1)'(acc_push) - (AW+1)'(acc_pop);
    // A fresh error in the same cycle as clr_err keeps the sticky bit set.
    overflow_next  = (bus.push & full)  | (overflow_reg  & ~bus.clr_err);
    underflow_next = (bus.pop  & empty) | (underflow_reg & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign bus.wr_en        = acc_push;
  assign bus.wr_addr      = wr_ptr_reg;
  assign bus.rd_addr      = rd_ptr_reg;
  assign bus.count        = count_reg;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_reg >= AF_C);
  assign bus.almost_empty = (count_reg <= AE_C);
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a small 8x8 storage model and a decoupled scoreboard monitor.
module tb_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] mem [8];
  logic [7:0] rd_data;

  fifo_ctrl_if #(.AW(3)) bus ();

  fifo_ctrl #(.AW(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.wr_en) mem[bus.wr_addr] <= wr_data;
  assign rd_data = mem[bus.rd_addr];

  typedef struct {
    string nm;
    int    wen, wa, ra, cnt, ov, un, data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_txn = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Expected state is what the DUT should present during the cycle the inputs are applied.
  task automatic step(input logic p, input logic r, input logic c, input int d, input string nm,
                      input int wen, input int wa, input int ra, input int cnt,
                      input int ov, input int un, input int data);
    exp_t x;
    @(posedge clk);
    #1;
    bus.push = p; bus.pop = r; bus.clr_err = c; wr_data = 8'(d);
    x.nm = nm; x.wen = wen; x.wa = wa; x.ra = ra; x.cnt = cnt;
    x.ov = ov; x.un = un; x.data = data;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_txn++;
      chk({e.nm, ".wr_en"},   32'(bus.wr_en),        32'(e.wen));
      chk({e.nm, ".wr_addr"}, 32'(bus.wr_addr),      32'(e.wa));
      chk({e.nm, ".rd_addr"}, 32'(bus.rd_addr),      32'(e.ra));
      chk({e.nm, ".count"},   32'(bus.count),        32'(e.cnt));
      chk({e.nm, ".full"},    32'(bus.full),         32'(e.cnt == 8));
      chk({e.nm, ".empty"},   32'(bus.empty),        32'(e.cnt == 0));
      chk({e.nm, ".afull"},   32'(bus.almost_full),  32'(e.cnt >= 6));
      chk({e.nm, ".aempty"},  32'(bus.almost_empty), 32'(e.cnt <= 1));
      chk({e.nm, ".ovf"},     32'(bus.overflow),     32'(e.ov));
      chk({e.nm, ".unf"},     32'(bus.underflow),    32'(e.un));
      if (e.data >= 0) chk({e.nm, ".rd_data"}, 32'(rd_data), 32'(e.data));
      $display("txn %0d %s wa=%0d ra=%0d cnt=%0d ovf=%0b unf=%0b", n_txn, e.nm,
               bus.wr_addr, bus.rd_addr, bus.count, bus.overflow, bus.underflow);
    end
  end

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.count", 32'(bus.count), 32'd0);
    chk("rst.empty", 32'(bus.empty), 32'd1);
    rst_n = 1'b1;

    step(0,0,0,0,"idle", 0,0,0,0, 0,0,-1);
    // Fill 0x10..0x17, then one push too many.
    for (int i = 0; i < 8; i++)
      step(1,0,0,'h10+i,"fill", 1,i,0,i, 0,0, (i > 0) ? 'h10 : -1);
    step(1,0,0,'h18,"fill9", 0,0,0,8, 0,0,'h10);
    step(0,0,0,0,"full_idle", 0,0,0,8, 1,0,'h10);
    for (int i = 0; i < 8; i++)
      step(0,1,0,0,"drain", 0,0,i,8-i, 1,0,'h10+i);
    step(0,1,0,0,"drain9", 0,0,0,0, 1,0,-1);
    step(0,0,1,0,"clr", 0,0,0,0, 1,1,-1);
    step(0,0,0,0,"clr_done", 0,0,0,0, 0,0,-1);

    // Wrap: push 5, pop 5, push 6 across the address wrap, pop 6.
    for (int i = 0; i < 5; i++)
      step(1,0,0,'h20+i,"wpush", 1,i,0,i, 0,0, (i > 0) ? 'h20 : -1);
    for (int i = 0; i < 5; i++)
      step(0,1,0,0,"wpop", 0,5,i,5-i, 0,0,'h20+i);
    for (int i = 0; i < 6; i++)
      step(1,0,0,'h30+i,"wpush6", 1,(5+i)%8,5,i, 0,0, (i > 0) ? 'h30 : -1);
    for (int i = 0; i < 6; i++)
      step(0,1,0,0,"wpop6", 0,3,(5+i)%8,6-i, 0,0,'h30+i);

    // Simultaneous push/pop at count 3 for 10 cycles.
    for (int i = 0; i < 3; i++)
      step(1,0,0,'h40+i,"spush", 1,3+i,3,i, 0,0, (i > 0) ? 'h40 : -1);
    for (int k = 0; k < 10; k++)
      step(1,1,0,'h50+k,"both", 1,(6+k)%8,(3+k)%8,3, 0,0, (k < 3) ? 'h40+k : 'h50+k-3);
    for (int i = 0; i < 5; i++)
      step(1,0,0,'h60+i,"topup", 1,i,5,3+i, 0,0,'h57);
    step(1,1,0,'h70,"both_full", 0,5,5,8, 0,0,'h57);
    step(0,0,0,0,"after_bf", 0,5,6,7, 1,0,'h58);
    for (int i = 0; i < 7; i++)
      step(0,1,0,0,"drain7", 0,5,(6+i)%8,7-i, 1,0, (i < 2) ? 'h58+i : 'h60+i-2);
    step(1,1,0,'h80,"both_empty", 1,5,5,0, 1,0,-1);
    step(0,0,0,0,"after_be", 0,6,5,1, 1,1,'h80);

    // Sticky error clear versus a simultaneous new overflow.
    step(0,0,1,0,"clr2", 0,6,5,1, 1,1,'h80);
    for (int i = 0; i < 7; i++)
      step(1,0,0,'h90+i,"refill", 1,(6+i)%8,5,1+i, 0,0,'h80);
    step(1,0,0,'hA0,"ovf", 0,5,5,8, 0,0,'h80);
    step(1,0,1,'hA1,"clr_ovf", 0,5,5,8, 1,0,'h80);
    step(0,0,1,0,"clr_only", 0,5,5,8, 1,0,'h80);
    step(0,0,0,0,"cleared", 0,5,5,8, 0,0,'h80);
    for (int i = 0; i < 4; i++)
      step(0,1,0,0,"pop4", 0,5,(5+i)%8,8-i, 0,0, (i == 0) ? 'h80 : 'h90+i-1);

    // Asynchronous reset at count 4, checked between clock edges.
    @(posedge clk);
    #1;
    bus.pop = 1'b0;
    #1;
    chk("pre_rst.count", 32'(bus.count), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("async_rst.count",   32'(bus.count),   32'd0);
    chk("async_rst.empty",   32'(bus.empty),   32'd1);
    chk("async_rst.wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("async_rst.rd_addr", 32'(bus.rd_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0,0,0,0,"post_rst", 0,0,0,0, 0,0,-1);
    step(0,0,0,0,"final", 0,0,0,0, 0,0,-1);
    @(negedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
